time_set_controller: RTL and testbench

Pushbutton-driven time-setting front end for the clock counter. It debounces four raw buttons and runs an edit state machine that captures the live time and lets the user step hours, minutes and seconds with wrap-around. On commit it drives range-checked `newHours`/`newMinutes`/`newSeconds` with a one-cycle `load` strobe. The top level ORs `load` with the system reset into the counter's load/reset input. `editing` and `field_sel` feed the display so the selected field can blink.

---
 rtl/time_set_controller.sv | 144 ++++++++++++++
 tb/tb_time_set_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - debounced pushbutton front end and edit FSM for setting the clock counter
module tsc_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching edge; press rises with it.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module time_set_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_set,
  input  logic [7:0] cur_hours,
  input  logic [7:0] cur_minutes,
  input  logic [7:0] cur_seconds,
  output logic [7:0] newHours,
  output logic [7:0] newMinutes,
  output logic [7:0] newSeconds,
  output logic       load,
  output logic       editing,
  output logic [1:0] field_sel
);
  typedef enum logic [2:0] {IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT} state_t;

  state_t     state;
  logic [7:0] sh_h;
  logic [7:0] sh_m;
  logic [7:0] sh_s;
  logic       p_mode;
  logic       p_up;
  logic       p_down;
  logic       p_set;

  tsc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .raw(btn_mode), .press(p_mode));
  tsc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .raw(btn_up), .press(p_up));
  tsc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .raw(btn_down), .press(p_down));
  tsc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .raw(btn_set), .press(p_set));

  function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic [7:0] max_v,
                                           input logic inc);
    if (inc) return (v >= max_v) ? 8'd0 : v + 8'd1;
    return (v == 8'd0) ? max_v : v - 8'd1;
  endfunction

  // Priority inside an edit: set, then mode, then up/down (both together cancel).
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state     <= IDLE;
      sh_h      <= 8'd0;
      sh_m      <= 8'd0;
      sh_s      <= 8'd0;
      load      <= 1'b0;
      editing   <= 1'b0;
      field_sel <= 2'd0;
    end else begin
      load <= 1'b0;
      case (state)
        IDLE: begin
          if (p_mode) begin
            sh_h      <= (cur_hours   < 8'd24) ? cur_hours   : 8'd0;
            sh_m      <= (cur_minutes < 8'd60) ? cur_minutes : 8'd0;
            sh_s      <= (cur_seconds < 8'd60) ? cur_seconds : 8'd0;
            state     <= EDIT_H;
            editing   <= 1'b1;
            field_sel <= 2'd1;
          end
        end
        EDIT_H, EDIT_M, EDIT_S: begin
          if (p_set) begin
            state     <= COMMIT;
            load      <= 1'b1;
            editing   <= 1'b0;
            field_sel <= 2'd0;
          end else if (p_mode) begin
            case (state)
              EDIT_H:  begin state <= EDIT_M; field_sel <= 2'd2; end
              EDIT_M:  begin state <= EDIT_S; field_sel <= 2'd3; end
              default: begin state <= EDIT_H; field_sel <= 2'd1; end
            endcase
          end else if (p_up ^ p_down) begin
            case (state)
              EDIT_H:  sh_h <= wrap_step(sh_h, 8'd23, p_up);
              EDIT_M:  sh_m <= wrap_step(sh_m, 8'd59, p_up);
              default: sh_s <= wrap_step(sh_s, 8'd59, p_up);
            endcase
          end
        end
        COMMIT: state <= IDLE;
        default: begin
          state     <= IDLE;
          editing   <= 1'b0;
          field_sel <= 2'd0;
        end
      endcase
    end
  end

  assign newHours   = sh_h;
  assign newMinutes = sh_m;
  assign newSeconds = sh_s;
endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - directed bench with a per-cycle behavioural model of time_set_controller
module tb_time_set_controller;
  localparam int D = 4;

  logic       CLK100MHZ = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_set = 1'b0;
  logic [7:0] cur_hours = 8'd0;
  logic [7:0] cur_minutes = 8'd0;
  logic [7:0] cur_seconds = 8'd0;
  logic [7:0] newHours;
  logic [7:0] newMinutes;
  logic [7:0] newSeconds;
  logic       load;
  logic       editing;
  logic [1:0] field_sel;

  time_set_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_set(btn_set),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .newHours(newHours), .newMinutes(newMinutes), .newSeconds(newSeconds),
    .load(load), .editing(editing), .field_sel(field_sel));

  always #5 CLK100MHZ = ~CLK100MHZ;

  int checks = 0;
  int passed = 0;
  int load_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Model: phase 0 idle, 1..3 editing that field, 4 commit cycle.
  int       m_h = 0, m_m = 0, m_s = 0, m_ph = 0;
  bit [3:0] m_lvl = '0;
  bit [3:0] m_press = '0;
  bit       raw_hist [4][2];
  bit       views [4][D];

  task automatic model_step();
    bit [3:0] raw;
    bit [3:0] np;
    bit       all_diff;
    raw = {btn_set, btn_down, btn_up, btn_mode};
    np = '0;
    if (reset) begin
      m_h = 0; m_m = 0; m_s = 0; m_ph = 0;
      m_lvl = '0; m_press = '0;
      for (int b = 0; b < 4; b++) begin
        raw_hist[b][0] = 0; raw_hist[b][1] = 0;
        for (int i = 0; i < D; i++) views[b][i] = 0;
      end
      return;
    end
    if (m_ph == 4) m_ph = 0;
    else if (m_ph == 0) begin
      if (m_press[0]) begin
        m_h = (cur_hours < 24) ? int'(cur_hours) : 0;
        m_m = (cur_minutes < 60) ? int'(cur_minutes) : 0;
        m_s = (cur_seconds < 60) ? int'(cur_seconds) : 0;
        m_ph = 1;
      end
    end else begin
      if (m_press[3]) m_ph = 4;
      else if (m_press[0]) m_ph = (m_ph % 3) + 1;
      else if (m_press[1] != m_press[2]) begin
        int d;
        d = m_press[1] ? 1 : -1;
        if (m_ph == 1) m_h = (m_h + d + 24) % 24;
        else if (m_ph == 2) m_m = (m_m + d + 60) % 60;
        else m_s = (m_s + d + 60) % 60;
      end
    end
    // A button's debounced level changes once the last D synchronised samples all disagree with it.
    for (int b = 0; b < 4; b++) begin
      for (int i = D - 1; i > 0; i--) views[b][i] = views[b][i-1];
      views[b][0] = raw_hist[b][1];
      raw_hist[b][1] = raw_hist[b][0];
      raw_hist[b][0] = raw[b];
      all_diff = 1;
      for (int i = 0; i < D; i++) if (views[b][i] == m_lvl[b]) all_diff = 0;
      if (all_diff) begin
        np[b] = !m_lvl[b];
        m_lvl[b] = !m_lvl[b];
      end
    end
    m_press = np;
  endtask

  initial forever begin
    @(posedge CLK100MHZ);
    model_step();
  end

  initial begin
    @(posedge CLK100MHZ);
    forever begin
      @(negedge CLK100MHZ);
      if (load) load_cnt++;
      chk("model newHours", newHours, m_h);
      chk("model newMinutes", newMinutes, m_m);
      chk("model newSeconds", newSeconds, m_s);
      chk("model load", load, (m_ph == 4) ? 1 : 0);
      chk("model editing", editing, (m_ph >= 1 && m_ph <= 3) ? 1 : 0);
      chk("model field_sel", field_sel, (m_ph <= 3) ? m_ph : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic drive(input int b, input logic v);
    case (b)
      0: btn_mode = v;
      1: btn_up = v;
      2: btn_down = v;
      default: btn_set = v;
    endcase
  endtask

  task automatic press(input int b, input int times);
    repeat (times) begin
      drive(b, 1'b1);
      tick(8);
      drive(b, 1'b0);
      tick(8);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, " hours"}, newHours, h);
    chk({tag, " minutes"}, newMinutes, m);
    chk({tag, " seconds"}, newSeconds, s);
  endtask

  int loads_before;

  initial begin
    tick(3);
    reset = 1'b0;
    tick(2);
    chk_time("reset", 0, 0, 0);
    chk("reset load", load, 0);
    chk("reset editing", editing, 0);
    chk("reset field_sel", field_sel, 0);

    btn_up = 1'b1; tick(3); btn_up = 1'b0; tick(10);
    btn_up = 1'b1; tick(10); btn_up = 1'b0; tick(10);
    chk("idle up editing", editing, 0);
    chk_time("idle up", 0, 0, 0);
    chk("idle up loads", load_cnt, 0);

    cur_hours = 8'd13; cur_minutes = 8'd45; cur_seconds = 8'd7;
    press(0, 1);
    chk("enter editing", editing, 1);
    chk("enter field_sel", field_sel, 1);
    chk_time("capture", 13, 45, 7);
    press(1, 11);
    chk("hours wrap up", newHours, 0);
    press(2, 1);
    chk("hours wrap down", newHours, 23);
    press(0, 1);
    chk("to minutes", field_sel, 2);
    press(1, 15);
    chk("minutes wrap up", newMinutes, 0);
    press(2, 1);
    chk("minutes wrap down", newMinutes, 59);
    press(0, 1);
    chk("to seconds", field_sel, 3);
    press(0, 1);
    chk("back to hours", field_sel, 1);
    loads_before = load_cnt;
    press(3, 1);
    chk("first commit loads", load_cnt - loads_before, 1);
    chk_time("first commit", 23, 59, 7);

    cur_hours = 8'd30; cur_minutes = 8'd75; cur_seconds = 8'd99;
    press(0, 1);
    chk_time("out of range capture", 0, 0, 0);
    press(1, 9);
    press(0, 1);
    press(1, 5);
    press(0, 1);
    press(2, 1);
    chk_time("edited", 9, 5, 59);
    loads_before = load_cnt;
    press(3, 1);
    chk("commit loads", load_cnt - loads_before, 1);
    chk_time("commit", 9, 5, 59);
    chk("commit field_sel", field_sel, 0);
    chk("commit editing", editing, 0);
    press(1, 1);
    chk_time("post commit up", 9, 5, 59);

    cur_hours = 8'd1; cur_minutes = 8'd2; cur_seconds = 8'd3;
    press(0, 3);
    chk("simul field_sel", field_sel, 3);
    loads_before = load_cnt;
    btn_set = 1'b1; btn_up = 1'b1; tick(8);
    btn_set = 1'b0; btn_up = 1'b0; tick(8);
    chk("simul loads", load_cnt - loads_before, 1);
    chk_time("simul", 1, 2, 3);
    chk("simul editing", editing, 0);

    cur_hours = 8'd5; cur_minutes = 8'd6; cur_seconds = 8'd7;
    press(0, 2);
    chk("pre reset field_sel", field_sel, 2);
    loads_before = load_cnt;
    reset = 1'b1; tick(2); reset = 1'b0; tick(4);
    chk_time("mid edit reset", 0, 0, 0);
    chk("mid edit reset editing", editing, 0);
    chk("mid edit reset field_sel", field_sel, 0);
    chk("mid edit reset loads", load_cnt - loads_before, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
